// File: rtl/aes_dec_pkg.sv
// Shared types, constants and byte helpers for the AES-128 decrypt datapath.
package aes_dec_pkg;

  // Number of bytes in one 128-bit AES state word.
  localparam int NB_BYTES = 16;

  // Control states of the iterative inverse-SubBytes engine.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } isb_state_t;

  // Byte i of a state word; byte 0 is the most significant byte.
  function automatic logic [7:0] get_byte(input logic [127:0] state,
                                          input logic [3:0]   i);
    return state[{4'd15 - i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box: inverse affine transform followed by GF(2^8) inversion.
module inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Inverse of the S-box affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  endfunction

  // Purely combinational substitution of one byte.
  always_comb begin
    y_o = gf_inv(inv_affine(a_i));
  end

endmodule

// File: rtl/inv_subbytes_seq.sv
// Iterative inverse-SubBytes engine: LANES shared inverse S-boxes sweep the
// 16 state bytes over 16/LANES cycles between two valid/ready handshakes.
// LANES must be one of 1, 2, 4, 8, 16.
module inv_subbytes_seq
  import aes_dec_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int GROUPS = NB_BYTES / LANES;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

  isb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     work_q, work_d;
  logic             in_ready_q, out_valid_q, busy_q;

  logic [3:0] lane_idx_s [LANES];
  logic [7:0] lane_in_s  [LANES];
  logic [7:0] lane_out_s [LANES];

  // Lane j always works on byte cnt*LANES + j of the working register.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign lane_idx_s[j] = 4'((32'(cnt_q) * LANES) + j);
    assign lane_in_s[j]  = get_byte(work_q, lane_idx_s[j]);

    inv_sbox u_inv_sbox (
      .a_i (lane_in_s[j]),
      .y_o (lane_out_s[j])
    );
  end

  // Next-state, counter and working-register update; flush overrides all.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    if (flush) begin
      // Abort keeps the working register so a partial result stays visible.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_d  = in_state;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          for (int j = 0; j < LANES; j++) begin
            work_d[{4'd15 - lane_idx_s[j], 3'b000} +: 8] = lane_out_s[j];
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d = RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter, data and handshake flags; flags follow the next state so
  // they are registered yet aligned with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= 128'h0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = work_q;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Self-checking bench for inv_subbytes_seq: directed scenarios plus random
// blocks checked against a table-based inverse S-box model.
module tb_inv_subbytes_seq;

  localparam logic [127:0] RAMP     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RAMP_EXP = 128'h52096ad53036a538bf40a39e81f3d7fb;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, out_ready;
  logic [127:0] in_state;

  logic in_ready_4, out_valid_4, busy_4;   logic [127:0] out_state_4;
  logic in_ready_1, out_valid_1, busy_1;   logic [127:0] out_state_1;
  logic in_ready_2, out_valid_2, busy_2;   logic [127:0] out_state_2;
  logic in_ready_16, out_valid_16, busy_16; logic [127:0] out_state_16;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_q[$];
  logic [127:0] res_q[$];
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  inv_subbytes_seq #(.LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_4),
    .in_state(in_state), .out_valid(out_valid_4), .out_ready(out_ready),
    .out_state(out_state_4), .busy(busy_4));
  inv_subbytes_seq #(.LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_1),
    .in_state(in_state), .out_valid(out_valid_1), .out_ready(out_ready),
    .out_state(out_state_1), .busy(busy_1));
  inv_subbytes_seq #(.LANES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_2),
    .in_state(in_state), .out_valid(out_valid_2), .out_ready(out_ready),
    .out_state(out_state_2), .busy(busy_2));
  inv_subbytes_seq #(.LANES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_16),
    .in_state(in_state), .out_valid(out_valid_16), .out_ready(out_ready),
    .out_state(out_state_16), .busy(busy_16));

  // Record accept cycles and accepted results of the LANES=4 instance.
  always @(posedge clk) begin
    if (rst_n && !flush && in_valid && in_ready_4) acc_q.push_back(cyc);
    if (rst_n && !flush && out_valid_4 && out_ready) res_q.push_back(out_state_4);
    cyc++;
  end

  // Reference model: GF(2^8) product by shift-and-add on plain integers.
  function automatic int m_mul(input int a, input int b);
    int x, y, p;
    x = a; y = b; p = 0;
    while (y != 0) begin
      if ((y & 1) != 0) p = p ^ x;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 283;
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic int rotl8(input int v, input int n);
    return ((v << n) | (v >> (8 - n))) & 255;
  endfunction

  // Forward S-box by brute-force inversion and affine map, then invert the table.
  task automatic build_model();
    int inv, f;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (m_mul(x, y) == 1) inv = y;
      f = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_tab[f] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   b;
    r = 128'h0;
    for (int i = 0; i < 16; i++) begin
      b = s[127-8*i -: 8];
      r[127-8*i -: 8] = inv_tab[b];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer s until the LANES=4 instance accepts it; in_valid is left high.
  task automatic send(input logic [127:0] s, output bit ok);
    in_state = s;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      ok = in_ready_4;
      tick();
    end
  endtask

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = 128'h0;
    #12;
    n_checks++; if (in_ready_4 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready_4); end
    n_checks++; if (out_valid_4 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid_4); end
    n_checks++; if (busy_4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_4); end
    n_checks++; if (out_state_4 !== 128'h0) begin n_fail++; $display("FAIL reset_out_state: got %h want 0", out_state_4); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ramp();
    bit ok, low_ok;
    int lat;
    out_ready = 1'b1;
    send(RAMP, ok);
    in_valid = 1'b0;
    lat = 0; low_ok = 1'b1;
    while (out_valid_4 !== 1'b1 && lat < 40) begin
      if (in_ready_4 !== 1'b0) low_ok = 1'b0;
      tick();
      lat++;
    end
    if (in_ready_4 !== 1'b0) low_ok = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ramp_accept: got 0 want 1"); end
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL ramp_latency: got %0d want 4", lat); end
    n_checks++; if (!low_ok) begin n_fail++; $display("FAIL ramp_in_ready_low: got high want low"); end
    n_checks++; if (out_state_4 !== RAMP_EXP) begin n_fail++; $display("FAIL ramp_out_state: got %h want %h", out_state_4, RAMP_EXP); end
    n_checks++; if (busy_4 !== 1'b1) begin n_fail++; $display("FAIL ramp_busy: got %b want 1", busy_4); end
    tick();
    n_checks++; if (out_valid_4 !== 1'b0 || in_ready_4 !== 1'b1) begin n_fail++; $display("FAIL ramp_after_out: got valid=%b ready=%b want 0 1", out_valid_4, in_ready_4); end
  endtask

  task automatic test_backpressure();
    bit ok, stable;
    int h0, k;
    out_ready = 1'b0;
    h0 = res_q.size();
    send({16{8'h63}}, ok);
    in_valid = 1'b0;
    k = 0;
    while (out_valid_4 !== 1'b1 && k < 40) begin tick(); k++; end
    n_checks++; if (out_valid_4 !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b want 1", out_valid_4); end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid_4 !== 1'b1 || out_state_4 !== 128'h0) stable = 1'b0;
    end
    n_checks++; if (!stable) begin n_fail++; $display("FAIL bp_stable: got valid=%b state=%h want 1 0", out_valid_4, out_state_4); end
    n_checks++; if (res_q.size() != h0) begin n_fail++; $display("FAIL bp_no_transfer: got %0d want %0d", res_q.size(), h0); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid_4 !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", out_valid_4); end
    tick(); tick();
    n_checks++; if (res_q.size() != h0 + 1) begin n_fail++; $display("FAIL bp_one_transfer: got %0d want %0d", res_q.size() - h0, 1); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int a0, r0, k;
    out_ready = 1'b1;
    a0 = acc_q.size(); r0 = res_q.size();
    send({16{8'h52}}, ok1);
    send({16{8'h00}}, ok2);
    in_valid = 1'b0;
    k = 0;
    while (res_q.size() < r0 + 2 && k < 40) begin tick(); k++; end
    n_checks++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL b2b_accepts: got %b%b want 11", ok1, ok2); end
    n_checks++;
    if (acc_q.size() < a0 + 2) begin n_fail++; $display("FAIL b2b_interval: got %0d accepts want 2", acc_q.size() - a0); end
    else if (acc_q[a0+1] - acc_q[a0] != 6) begin n_fail++; $display("FAIL b2b_interval: got %0d want 6", acc_q[a0+1] - acc_q[a0]); end
    n_checks++;
    if (res_q.size() < r0 + 2) begin n_fail++; $display("FAIL b2b_results: got %0d results want 2", res_q.size() - r0); end
    else if (res_q[r0] !== {16{8'h48}} || res_q[r0+1] !== {16{8'h52}}) begin
      n_fail++; $display("FAIL b2b_results: got %h %h want %h %h", res_q[r0], res_q[r0+1], {16{8'h48}}, {16{8'h52}});
    end
  endtask

  task automatic test_flush();
    bit ok, seen;
    int r0, k;
    logic [127:0] s;
    out_ready = 1'b1;
    r0 = res_q.size();
    send(RAMP, ok);
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (in_ready_4 !== 1'b1 || out_valid_4 !== 1'b0 || busy_4 !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: got ready=%b valid=%b busy=%b want 1 0 0", in_ready_4, out_valid_4, busy_4); end
    n_checks++; if (out_state_4 !== 128'h52096ad5_0405060708090a0b0c0d0e0f) begin
      n_fail++; $display("FAIL flush_keeps_work: got %h want %h", out_state_4, 128'h52096ad5_0405060708090a0b0c0d0e0f); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); if (out_valid_4 !== 1'b0) seen = 1'b1; end
    n_checks++; if (seen || res_q.size() != r0) begin n_fail++; $display("FAIL flush_no_output: got valid_seen=%b results=%0d want 0 0", seen, res_q.size() - r0); end
    s = rand_state();
    send(s, ok);
    in_valid = 1'b0;
    k = 0;
    while (res_q.size() == r0 && k < 40) begin tick(); k++; end
    n_checks++; if (res_q.size() == r0 || res_q[r0] !== ref_sub(s)) begin
      n_fail++; $display("FAIL flush_next_block: got %h want %h", (res_q.size() > r0) ? res_q[r0] : 128'hx, ref_sub(s)); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int r0, k;
    logic [127:0] s;
    out_ready = 1'b1;
    send(rand_state(), ok);
    in_valid = 1'b0;
    tick(); tick();
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (in_ready_4 !== 1'b1 || out_valid_4 !== 1'b0 || busy_4 !== 1'b0 || out_state_4 !== 128'h0) begin
      n_fail++; $display("FAIL async_reset: got ready=%b valid=%b busy=%b state=%h want 1 0 0 0", in_ready_4, out_valid_4, busy_4, out_state_4); end
    #2 rst_n = 1'b1;
    tick();
    r0 = res_q.size();
    s = rand_state();
    send(s, ok);
    in_valid = 1'b0;
    k = 0;
    while (res_q.size() == r0 && k < 40) begin tick(); k++; end
    n_checks++; if (res_q.size() == r0 || res_q[r0] !== ref_sub(s)) begin
      n_fail++; $display("FAIL reset_next_block: got %h want %h", (res_q.size() > r0) ? res_q[r0] : 128'hx, ref_sub(s)); end
  endtask

  task automatic test_lanes_sweep();
    int l1, l2, l4, l16;
    logic [127:0] s1, s2, s4, s16;
    l1 = -1; l2 = -1; l4 = -1; l16 = -1;
    s1 = 128'h0; s2 = 128'h0; s4 = 128'h0; s16 = 128'h0;
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_state = RAMP;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (l1 < 0 && out_valid_1 === 1'b1) begin l1 = k; s1 = out_state_1; end
      if (l2 < 0 && out_valid_2 === 1'b1) begin l2 = k; s2 = out_state_2; end
      if (l4 < 0 && out_valid_4 === 1'b1) begin l4 = k; s4 = out_state_4; end
      if (l16 < 0 && out_valid_16 === 1'b1) begin l16 = k; s16 = out_state_16; end
    end
    n_checks++; if (l1 != 16) begin n_fail++; $display("FAIL sweep_lat_l1: got %0d want 16", l1); end
    n_checks++; if (l2 != 8) begin n_fail++; $display("FAIL sweep_lat_l2: got %0d want 8", l2); end
    n_checks++; if (l4 != 4) begin n_fail++; $display("FAIL sweep_lat_l4: got %0d want 4", l4); end
    n_checks++; if (l16 != 1) begin n_fail++; $display("FAIL sweep_lat_l16: got %0d want 1", l16); end
    n_checks++; if (s1 !== RAMP_EXP) begin n_fail++; $display("FAIL sweep_state_l1: got %h want %h", s1, RAMP_EXP); end
    n_checks++; if (s2 !== RAMP_EXP) begin n_fail++; $display("FAIL sweep_state_l2: got %h want %h", s2, RAMP_EXP); end
    n_checks++; if (s4 !== RAMP_EXP) begin n_fail++; $display("FAIL sweep_state_l4: got %h want %h", s4, RAMP_EXP); end
    n_checks++; if (s16 !== RAMP_EXP) begin n_fail++; $display("FAIL sweep_state_l16: got %h want %h", s16, RAMP_EXP); end
  endtask

  task automatic test_random();
    bit ok;
    int r0, k;
    logic [127:0] s, e;
    for (int n = 0; n < 16; n++) begin
      s = rand_state();
      e = ref_sub(s);
      r0 = res_q.size();
      out_ready = 1'b1;
      send(s, ok);
      in_valid = 1'b0;
      k = 0;
      while (res_q.size() == r0 && k < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        k++;
      end
      n_checks++; if (res_q.size() == r0 || res_q[r0] !== e) begin
        n_fail++; $display("FAIL random_block_%0d: got %h want %h", n, (res_q.size() > r0) ? res_q[r0] : 128'hx, e); end
    end
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    build_model();
    test_reset();
    test_ramp();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid_run();
    test_lanes_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case a scenario wedges despite its own cycle bounds.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/inv_subbytes_seq.md
# inv_subbytes_seq

Iterative inverse-SubBytes engine for the AES-128 decrypt path. It accepts a 128-bit state word over a valid/ready handshake and runs it through LANES shared `inv_sbox` instances, processing LANES bytes per cycle. It returns the fully substituted state over a second valid/ready handshake. It sits between the InvShiftRows and AddRoundKey stages of an area-reduced decrypt round, in place of 16 parallel inverse S-boxes.

## Interface
- LANES, default 4: number of `inv_sbox` instances; legal values are 1, 2, 4, 8 and 16 (must divide 16).
- clk  in  1: single clock, rising edge.
- rst_n  in  1: reset, asynchronous assert, active-low.
- flush  in  1: synchronous abort to IDLE; has priority over all handshakes.
- in_valid  in  1: in_state is valid.
- in_ready  out  1: engine can accept; high only in IDLE.
- in_state  in  128: input state; byte i = in_state[127-8i -: 8].
- out_valid  out  1: out_state holds a finished result.
- out_ready  in  1: consumer accepts the result.
- out_state  out  128: substituted state, same byte order as in_state.
- busy  out  1: high in RUN or DONE.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_state into the working register, clear the byte-group counter cnt, and go to RUN.
  - RUN: each cycle, replace bytes cnt*LANES … cnt*LANES+LANES-1 of the working register with their inverse S-box values, then increment cnt. When cnt==16/LANES-1, go to DONE.
  - DONE: out_valid=1. Hold out_state stable until out_ready; on out_valid&&out_ready, go to IDLE.
- cnt is $clog2(16/LANES) bits wide, minimum 1 bit. It wraps to 0 on the last group. For LANES=16, RUN lasts exactly one cycle.
- out_state is driven directly from the working register. It is meaningful only while out_valid=1.
- flush=1 at any edge: go to IDLE and clear cnt; the working register keeps its contents. A flush in the same cycle as an input handshake drops that input. A flush in DONE drops the result with no out handshake.
- in_valid in RUN or DONE is ignored because in_ready=0; no back-to-back overlap.
- out_ready while not in DONE is ignored.
- rst_n low, even mid-RUN: immediately go to IDLE, cnt=0, working register=0.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_state=128'h0.
- Input handshake at edge E0. RUN occupies edges E1…E(16/LANES). out_valid rises after edge E(16/LANES).
- Latency from input handshake to out_valid is 16/LANES cycles; with LANES=4 it is 4 cycles.
- With out_ready held high, the output handshake is one cycle after out_valid rises. in_ready returns the cycle after that.
- Minimum initiation interval is 16/LANES+2 cycles; with LANES=4 it is 6 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Substitution path per RUN cycle: working-register byte mux, then `inv_sbox`, then register write-back.

## Structure
- Shared package `aes_dec_pkg` holds:
  - `isb_state_t` enum {IDLE, RUN, DONE}
  - localparam NB_BYTES=16
  - byte-slice helper function `get_byte(state, i)`
- Sub-module: LANES instances of the existing `inv_sbox`, in a generate loop. Lane j is fed working-register byte cnt*LANES+j.
- No other sub-modules. The FSM, counter and working register live in `inv_subbytes_seq`.

## Test plan
- Ramp input, LANES=4: in_state=128'h000102030405060708090a0b0c0d0e0f with out_ready=1 → out_state=128'h52096ad53036a538bf40a39e81f3d7fb. out_valid rises exactly 4 cycles after the handshake; in_ready is low throughout.
- Backpressure: input all 8'h63, out_ready=0 for 10 cycles → out_valid and out_state=128'h0 stay stable; exactly one transfer occurs when out_ready rises.
- Back-to-back: two inputs offered with in_valid held high (8'h52 repeated, then 8'h00 repeated) → results 8'h48 repeated, then 8'h52 repeated; second accept 6 cycles after the first.
- Flush at RUN cycle 2 → in_ready=1 next cycle, no out_valid; the following block completes correctly.
- rst_n pulsed low mid-RUN, asynchronously between edges → outputs return to reset values immediately; a new block after reset is correct.
- Sweep LANES ∈ {1,2,16} with the ramp vector → identical out_state, latencies 16, 8 and 1 cycles.
